// File: rtl/zeroriscy_arb_pkg.sv
// Shared definitions for the instruction-SRAM arbiter: the owner id that is
// carried through the outstanding-transaction FIFO and the depth limit.
package zeroriscy_arb_pkg;

    typedef logic owner_t;

    localparam owner_t OWNER_FETCH = 1'b0;
    localparam owner_t OWNER_DATA  = 1'b1;

    parameter int unsigned ARB_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/zeroriscy_owner_fifo.sv
// Count-based FIFO with a combinational head, used to remember which master
// owns each issued-but-unanswered slave transaction.
module zeroriscy_owner_fifo
    import zeroriscy_arb_pkg::*;
#(
    parameter int unsigned DEPTH = ARB_MAX_OUTSTANDING,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/zeroriscy_sram_arb.sv
// Shares one word-wide req/gnt/rvalid SRAM slave between instruction fetch
// (m0) and the data/loader port (m1); responses are routed by an owner FIFO.
module zeroriscy_sram_arb
    import zeroriscy_arb_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_req,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic        s_err,
    input  logic [31:0] s_rdata,
    output logic        proto_err
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

    logic             prio_q, prio_d;
    logic             proto_err_q, proto_err_d;
    owner_t           winner, head;
    logic             win_req, can_issue, accept, pop, spurious;
    logic             fifo_empty, fifo_full;
    logic [CNT_W-1:0] count;

    zeroriscy_owner_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (winner),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    always_comb begin
        if (m0_req && m1_req) begin
            winner = FIXED_PRIO ? OWNER_FETCH : owner_t'(prio_q);
        end else begin
            winner = m1_req ? OWNER_DATA : OWNER_FETCH;
        end
        win_req  = m0_req || m1_req;
        pop      = s_rvalid && !fifo_empty;
        spurious = s_rvalid && (count == '0);
        // A full FIFO can still take a new entry when its head retires now.
        can_issue = !fifo_full || pop;
        s_req     = win_req && can_issue;
        accept    = s_req && s_gnt;

        s_we    = m0_we;
        s_be    = m0_be;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        if (s_req && (winner == OWNER_DATA)) begin
            s_we    = m1_we;
            s_be    = m1_be;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end

        m0_gnt    = accept && (winner == OWNER_FETCH);
        m1_gnt    = accept && (winner == OWNER_DATA);
        m0_rvalid = pop && (head == OWNER_FETCH);
        m1_rvalid = pop && (head == OWNER_DATA);
        m0_err    = m0_rvalid && s_err;
        m1_err    = m1_rvalid && s_err;
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;

        prio_d = prio_q;
        if (!FIXED_PRIO && accept) begin
            prio_d = ~winner;
        end
        proto_err_d = proto_err_q || spurious;
        proto_err   = proto_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_zeroriscy_sram_arb.sv
// Checks a round-robin (a_) and a fixed-priority (b_) arbiter that share the
// same master and slave stimulus against queue-based reference models.
module tb_zeroriscy_sram_arb;

    localparam int unsigned OUTS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        s_gnt, s_rvalid, s_err;
    logic [31:0] s_rdata;

    logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_m0_err, a_m1_err;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
    logic        a_s_req, a_s_we, a_proto_err;
    logic [3:0]  a_s_be;
    logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_m0_err, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
    logic        b_s_req, b_s_we, b_proto_err;
    logic [3:0]  b_s_be;

    zeroriscy_sram_arb #(.OUTSTANDING(OUTS), .FIXED_PRIO(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata), .m0_err(a_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata), .m1_err(a_m1_err),
        .s_req(a_s_req), .s_we(a_s_we), .s_be(a_s_be), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
        .proto_err(a_proto_err)
    );

    zeroriscy_sram_arb #(.OUTSTANDING(OUTS), .FIXED_PRIO(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
        .s_req(b_s_req), .s_we(b_s_we), .s_be(b_s_be), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
        .proto_err(b_proto_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] smem [256];
    logic [31:0] rmem [256];
    logic [31:0] pend [$];
    bit          oq_a [$];
    bit          oq_b [$];
    logic [32:0] dq [$];
    bit          prio_a, proto_a, proto_b;
    bit          rv_rand, err_rand;
    bit          sn_ag0, sn_ag1, sn_bg0, sn_bg1, sn_sreq, sn_rv0, sn_rv1, sn_proto, sn_we;
    bit          eg0, eg1;
    logic [31:0] sn_addr, sn_rdata;
    logic [3:0]  sn_be;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic bit pick(input bit fixed, input bit p);
        if (m0_req && m1_req) return fixed ? 1'b0 : p;
        return !m0_req;
    endfunction

    task automatic cycle(input bit allow_rv, input bit force_rv);
        int unsigned na, nb;
        bit          wa, wb, ia, ib, ga, gb, pa, pb, oa, ob, sw;
        logic [31:0] saddr, swd, ea, wad, wwd;
        logic [3:0]  sbe, wbe;
        logic [7:0]  idx;
        s_rvalid = force_rv || (allow_rv && pend.size() > 0 && (!rv_rand || $urandom_range(0, 1) == 1));
        s_rdata  = (pend.size() > 0 && !force_rv) ? pend[0] : $urandom;
        s_err    = s_rvalid && err_rand && ($urandom_range(0, 3) == 0);
        #3;
        na = oq_a.size();
        nb = oq_b.size();
        wa = pick(1'b0, prio_a);
        wb = pick(1'b1, 1'b0);
        ia = (m0_req || m1_req) && (na < OUTS || (s_rvalid && na > 0));
        ib = (m0_req || m1_req) && (nb < OUTS || (s_rvalid && nb > 0));
        ga = ia && s_gnt;
        gb = ib && s_gnt;
        pa = s_rvalid && na > 0;
        pb = s_rvalid && nb > 0;
        oa = (na > 0) ? oq_a[0] : 1'b0;
        ob = (nb > 0) ? oq_b[0] : 1'b0;
        eg0 = ga && !wa;
        eg1 = ga && wa;
        ea = (ia && wa) ? m1_addr : m0_addr;
        chk("a_s_req", a_s_req, ia);
        chk("a_m0_gnt", a_m0_gnt, eg0);
        chk("a_m1_gnt", a_m1_gnt, eg1);
        chk("a_s_addr", a_s_addr, ea);
        chk("a_s_we", a_s_we, (ia && wa) ? m1_we : m0_we);
        chk("a_s_be", a_s_be, (ia && wa) ? m1_be : m0_be);
        chk("a_s_wdata", a_s_wdata, (ia && wa) ? m1_wdata : m0_wdata);
        chk("a_m0_rvalid", a_m0_rvalid, pa && !oa);
        chk("a_m1_rvalid", a_m1_rvalid, pa && oa);
        chk("a_m0_err", a_m0_err, pa && !oa && s_err);
        chk("a_m1_err", a_m1_err, pa && oa && s_err);
        if (pa && dq[0][32]) chk(oa ? "a_m1_rdata" : "a_m0_rdata", oa ? a_m1_rdata : a_m0_rdata, dq[0][31:0]);
        chk("a_proto", a_proto_err, proto_a);
        chk("b_s_req", b_s_req, ib);
        chk("b_m0_gnt", b_m0_gnt, gb && !wb);
        chk("b_m1_gnt", b_m1_gnt, gb && wb);
        chk("b_s_addr", b_s_addr, (ib && wb) ? m1_addr : m0_addr);
        chk("b_s_we", b_s_we, (ib && wb) ? m1_we : m0_we);
        chk("b_s_be", b_s_be, (ib && wb) ? m1_be : m0_be);
        chk("b_s_wdata", b_s_wdata, (ib && wb) ? m1_wdata : m0_wdata);
        chk("b_m0_rvalid", b_m0_rvalid, pb && !ob);
        chk("b_m1_rvalid", b_m1_rvalid, pb && ob);
        chk("b_m0_err", b_m0_err, pb && !ob && s_err);
        chk("b_m1_err", b_m1_err, pb && ob && s_err);
        chk("b_m0_rdata", b_m0_rdata, s_rdata);
        chk("b_m1_rdata", b_m1_rdata, s_rdata);
        chk("b_proto", b_proto_err, proto_b);
        sn_ag0 = a_m0_gnt;  sn_ag1 = a_m1_gnt;  sn_bg0 = b_m0_gnt;  sn_bg1 = b_m1_gnt;
        sn_sreq = a_s_req;  sn_rv0 = a_m0_rvalid; sn_rv1 = a_m1_rvalid; sn_proto = a_proto_err;
        sn_addr = a_s_addr; sn_be = a_s_be; sn_we = a_s_we; sn_rdata = a_m0_rdata;
        saddr = a_s_addr;   sbe = a_s_be;   sw = a_s_we;    swd = a_s_wdata;
        wad = wa ? m1_addr : m0_addr;
        wbe = wa ? m1_be : m0_be;
        wwd = wa ? m1_wdata : m0_wdata;
        @(posedge clk);
        if (s_rvalid && !force_rv && pend.size() > 0) void'(pend.pop_front());
        if (a_s_req === 1'b1 || sn_sreq) begin
            if (s_gnt) begin
                idx = saddr[9:2];
                pend.push_back(sw ? 32'h0 : smem[idx]);
                if (sw) smem[idx] = merge(smem[idx], swd, sbe);
            end
        end
        proto_a = proto_a || (s_rvalid && na == 0);
        proto_b = proto_b || (s_rvalid && nb == 0);
        if (pa) begin void'(oq_a.pop_front()); void'(dq.pop_front()); end
        if (pb) void'(oq_b.pop_front());
        if (ga) begin
            idx = wad[9:2];
            oq_a.push_back(wa);
            if (wa ? m1_we : m0_we) begin
                rmem[idx] = merge(rmem[idx], wwd, wbe);
                dq.push_back({1'b0, 32'h0});
            end else begin
                dq.push_back({1'b1, rmem[idx]});
            end
            prio_a = !wa;
        end
        if (gb) oq_b.push_back(wb);
        #1;
    endtask

    task automatic do_reset();
        m0_req = 1'b0; m1_req = 1'b0; s_rvalid = 1'b0; s_err = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_a_proto", a_proto_err, 1'b0);
        chk("rst_b_proto", b_proto_err, 1'b0);
        chk("rst_a_s_req", a_s_req, 1'b0);
        chk("rst_a_rvalid", {a_m0_rvalid, a_m1_rvalid, a_m0_gnt, a_m1_gnt}, 4'b0);
        oq_a.delete(); oq_b.delete(); dq.delete();
        prio_a = 1'b0; proto_a = 1'b0; proto_b = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        m0_req = 1'b0; m1_req = 1'b0;
        while ((pend.size() > 0 || oq_a.size() > 0) && guard < 40) begin
            cycle(1'b1, 1'b0);
            guard++;
        end
        chk("drain_left", pend.size(), 0);
    endtask

    initial begin
        rst = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b0; s_err = 1'b0; s_rdata = '0;
        m0_req = 0; m0_we = 0; m0_be = 4'hF; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = '0; m1_wdata = '0;
        rv_rand = 0; err_rand = 0;
        for (int i = 0; i < 256; i++) begin
            smem[i] = $urandom;
            rmem[i] = smem[i];
        end
        smem[64] = 32'hDEAD_BEEF;
        rmem[64] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        do_reset();
        cycle(1'b1, 1'b0);
        chk("idle_s_req", sn_sreq, 1'b0);

        // Fetch only
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0100;
        cycle(1'b1, 1'b0);
        chk("fetch_gnt", sn_ag0, 1'b1);
        m0_req = 0;
        cycle(1'b1, 1'b0);
        chk("fetch_rvalid", sn_rv0, 1'b1);
        chk("fetch_rdata", sn_rdata, 32'hDEAD_BEEF);
        chk("fetch_m1_rvalid", sn_rv1, 1'b0);
        drain();

        // Round-robin contention, and fixed priority on the second instance
        do_reset();
        m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0);
            chk("rr_m0_gnt", sn_ag0, (i % 2) == 0);
            chk("rr_m1_gnt", sn_ag1, (i % 2) == 1);
            if (i < 3) chk("fixed_m0_gnt", sn_bg0, 1'b1);
        end
        m0_req = 0;
        cycle(1'b1, 1'b0);
        chk("fixed_m1_gnt", sn_bg1, 1'b1);
        drain();

        // Backpressure
        do_reset();
        m1_req = 1; m1_we = 0; m1_addr = 32'h40; s_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            chk("bp_addr", sn_addr, 32'h40);
            chk("bp_gnt", {sn_ag0, sn_ag1}, 2'b00);
        end
        s_gnt = 1;
        cycle(1'b1, 1'b0);
        chk("bp_gnt_rise", {sn_ag0, sn_ag1}, 2'b01);
        drain();

        // Outstanding limit
        do_reset();
        m0_req = 1; m0_addr = 32'h8; m1_req = 1; m1_addr = 32'hC;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            chk("lim_s_req", sn_sreq, i < 2);
        end
        cycle(1'b1, 1'b0);
        chk("lim_resp_m0", sn_rv0, 1'b1);
        chk("lim_regrant", sn_ag0, 1'b1);
        drain();

        // Write, then spurious response
        do_reset();
        m1_req = 1; m1_we = 1; m1_be = 4'b0010; m1_wdata = 32'h0000_AB00; m1_addr = 32'h44;
        cycle(1'b1, 1'b0);
        chk("wr_be", sn_be, 4'b0010);
        chk("wr_we", sn_we, 1'b1);
        m1_req = 0; m1_we = 0; m1_be = 4'hF;
        cycle(1'b1, 1'b0);
        chk("wr_rvalid", sn_rv1, 1'b1);
        drain();
        cycle(1'b0, 1'b1);
        chk("spur_no_rvalid", {sn_rv0, sn_rv1}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            chk("proto_sticky", sn_proto, 1'b1);
        end

        // Reset mid-transaction, late response afterwards
        do_reset();
        m0_req = 1; m0_addr = 32'h1C;
        cycle(1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 1'b0);
        chk("late_no_rvalid", {sn_rv0, sn_rv1}, 2'b00);
        cycle(1'b0, 1'b0);
        chk("late_proto", sn_proto, 1'b1);
        drain();

        // Randomized traffic with masters holding requests until granted
        do_reset();
        rv_rand = 1; err_rand = 1;
        for (int i = 0; i < 400; i++) begin
            if (!m0_req) begin
                m0_req = $urandom_range(0, 2) != 0; m0_we = $urandom_range(0, 3) == 0;
                m0_be = $urandom; m0_addr = $urandom; m0_wdata = $urandom;
            end
            if (!m1_req) begin
                m1_req = $urandom_range(0, 2) != 0; m1_we = $urandom_range(0, 1) == 0;
                m1_be = $urandom; m1_addr = $urandom; m1_wdata = $urandom;
            end
            s_gnt = $urandom_range(0, 3) != 0;
            cycle(1'b1, 1'b0);
            if (eg0) m0_req = 0;
            if (eg1) m1_req = 0;
        end
        rv_rand = 0; err_rand = 0; s_gnt = 1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
